cpu_ctrl: RTL and testbench

- Instruction-sequencing controller for the CPU core, sitting between the instruction FIFO/fetch path, the ALU datapath and the data-memory unit.
- Pops one instruction at a time and decodes its opcode.
- Starts the ALU, waits for the ALU or memory completion strobes, resolves BEQ/BNE, and signals retirement.
- Exposes a small 32-bit register-mapped slave port for status and control.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/cpu_ctrl_regs.sv | 79 +++++++
 rtl/cpu_ctrl.sv | 126 ++++++++++++
 tb/tb_cpu_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencing controller:
// opcodes, FSM state encoding and slave register offsets.
package cpu_pkg;

    localparam int WORD_BITS = 32;
    localparam int INST_BITS = 32;

    localparam logic [5:0] OP_ALU = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM_RD = 3'd4,
        S_MEM_WR = 3'd5,
        S_BRANCH = 3'd6,
        S_DONE   = 3'd7
    } state_e;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_INST   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    function automatic logic op_uses_alu(input logic [5:0] op);
        return (op == OP_ALU) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/cpu_ctrl_regs.sv
// Slave register block: address decode, CTRL and INST_COUNT
// storage, and the registered one-cycle-latency read mux.
module cpu_ctrl_regs #(
    parameter int WORD_BITS = cpu_pkg::WORD_BITS,
    parameter int INST_BITS = cpu_pkg::INST_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           i_reg_sel,
    input  logic                 i_read,
    input  logic                 i_write,
    input  logic [WORD_BITS-1:0] i_writedata,
    input  logic [2:0]           i_state,
    input  logic                 i_empty,
    input  logic [INST_BITS-1:0] i_cur_inst,
    input  logic                 i_retire,
    output logic                 o_enable,
    output logic [WORD_BITS-1:0] o_readdata,
    output logic                 o_readdatavalid
);
    import cpu_pkg::*;

    logic                 enable_q, enable_d;
    logic [WORD_BITS-1:0] count_q, count_d;
    logic [WORD_BITS-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 ctrl_wr;
    logic [WORD_BITS-1:0] status;
    logic [WORD_BITS-1:0] mux;

    assign ctrl_wr = i_write && (i_reg_sel == REG_CTRL);
    assign status  = WORD_BITS'({i_empty, i_state, (i_state != 3'd0)});

    always_comb begin
        mux = '0;
        unique case (i_reg_sel)
            REG_STATUS: mux = status;
            REG_COUNT:  mux = count_q;
            REG_INST:   mux = WORD_BITS'(i_cur_inst);
            REG_CTRL:   mux = WORD_BITS'(enable_q);
        endcase
    end

    always_comb begin
        enable_d = enable_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        rvalid_d = i_read;
        if (i_retire)
            count_d = count_q + 1'b1;
        // Clear wins over a same-cycle retire increment.
        if (ctrl_wr) begin
            enable_d = i_writedata[0];
            if (i_writedata[1])
                count_d = '0;
        end
        if (i_read)
            rdata_d = mux;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q <= 1'b1;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            enable_q <= enable_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign o_enable        = enable_q;
    assign o_readdata      = rdata_q;
    assign o_readdatavalid = rvalid_q;

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction sequencing controller: fetch, decode, ALU/memory
// waits, branch resolution and retirement, plus a status port.
module cpu_ctrl #(
    parameter int WORD_BITS = cpu_pkg::WORD_BITS,
    parameter int INST_BITS = cpu_pkg::INST_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_empty,
    input  logic                 i_fetch_complete,
    input  logic [INST_BITS-1:0] i_inst,
    input  logic                 i_inst_valid,
    output logic                 o_inst_complete,
    output logic                 o_calc_start,
    input  logic                 i_calc_complete,
    input  logic                 i_read_mem_complete,
    input  logic                 i_write_mem_complete,
    input  logic [WORD_BITS-1:0] i_src0,
    input  logic [WORD_BITS-1:0] i_src1,
    output logic                 o_be_bne,
    input  logic [WORD_BITS-1:0] i_addr,
    input  logic                 i_read,
    input  logic                 i_write,
    input  logic [WORD_BITS-1:0] i_writedata,
    output logic [WORD_BITS-1:0] o_readdata,
    output logic                 o_readdatavalid
);
    import cpu_pkg::*;

    state_e               state_q, state_d;
    logic [INST_BITS-1:0] inst_q, inst_d;
    logic                 calc_q, calc_d;
    logic                 done_q, done_d;
    logic                 br_q, br_d;
    logic                 enable;
    logic [5:0]           op;
    logic                 taken;
    logic                 unused_addr;

    assign op    = inst_q[INST_BITS-1 -: 6];
    assign taken = ((op == OP_BEQ) && (i_src0 == i_src1)) ||
                   ((op == OP_BNE) && (i_src0 != i_src1));
    assign unused_addr = ^{i_addr[WORD_BITS-1:4], i_addr[1:0]};

    // Outputs are registered and aligned with the state they belong to.
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        unique case (state_q)
            S_IDLE:
                if (enable && !i_empty)
                    state_d = S_FETCH;
            S_FETCH:
                if (i_inst_valid || i_fetch_complete) begin
                    inst_d  = i_inst;
                    state_d = S_DECODE;
                end
            S_DECODE:
                state_d = op_uses_alu(op) ? S_EXEC : S_DONE;
            S_EXEC:
                if (i_calc_complete) begin
                    unique case (1'b1)
                        op == OP_LW:  state_d = S_MEM_RD;
                        op == OP_SW:  state_d = S_MEM_WR;
                        op == OP_BEQ,
                        op == OP_BNE: state_d = S_BRANCH;
                        default:      state_d = S_DONE;
                    endcase
                end
            S_MEM_RD:
                if (i_read_mem_complete)
                    state_d = S_DONE;
            S_MEM_WR:
                if (i_write_mem_complete)
                    state_d = S_DONE;
            S_BRANCH:
                state_d = S_DONE;
            S_DONE:
                state_d = S_IDLE;
        endcase
        calc_d = (state_d == S_DECODE) &&
                 op_uses_alu(inst_d[INST_BITS-1 -: 6]);
        done_d = (state_d == S_DONE);
        br_d   = (state_d == S_BRANCH) && taken;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            inst_q  <= '0;
            calc_q  <= 1'b0;
            done_q  <= 1'b0;
            br_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            calc_q  <= calc_d;
            done_q  <= done_d;
            br_q    <= br_d;
        end
    end

    assign o_calc_start    = calc_q;
    assign o_inst_complete = done_q;
    assign o_be_bne        = br_q;

    cpu_ctrl_regs #(
        .WORD_BITS(WORD_BITS),
        .INST_BITS(INST_BITS)
    ) u_regs (
        .clk            (clk),
        .rst            (rst),
        .i_reg_sel      (i_addr[3:2]),
        .i_read         (i_read),
        .i_write        (i_write),
        .i_writedata    (i_writedata),
        .i_state        (state_q),
        .i_empty        (i_empty),
        .i_cur_inst     (inst_q),
        .i_retire       (state_q == S_DONE),
        .o_enable       (enable),
        .o_readdata     (o_readdata),
        .o_readdatavalid(o_readdatavalid)
    );

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: instruction flows, enable/clear
// control, register map and mid-instruction reset.
module tb_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_empty;
    logic        i_fetch_complete;
    logic [31:0] i_inst;
    logic        i_inst_valid;
    logic        o_inst_complete;
    logic        o_calc_start;
    logic        i_calc_complete;
    logic        i_read_mem_complete;
    logic        i_write_mem_complete;
    logic [31:0] i_src0;
    logic [31:0] i_src1;
    logic        o_be_bne;
    logic [31:0] i_addr;
    logic        i_read;
    logic        i_write;
    logic [31:0] i_writedata;
    logic [31:0] o_readdata;
    logic        o_readdatavalid;

    int errors = 0;
    int checks = 0;
    int n_calc = 0;
    int n_done = 0;
    int n_br   = 0;

    cpu_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_empty             (i_empty),
        .i_fetch_complete    (i_fetch_complete),
        .i_inst              (i_inst),
        .i_inst_valid        (i_inst_valid),
        .o_inst_complete     (o_inst_complete),
        .o_calc_start        (o_calc_start),
        .i_calc_complete     (i_calc_complete),
        .i_read_mem_complete (i_read_mem_complete),
        .i_write_mem_complete(i_write_mem_complete),
        .i_src0              (i_src0),
        .i_src1              (i_src1),
        .o_be_bne            (o_be_bne),
        .i_addr              (i_addr),
        .i_read              (i_read),
        .i_write             (i_write),
        .i_writedata         (i_writedata),
        .o_readdata          (o_readdata),
        .o_readdatavalid     (o_readdatavalid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_calc_start === 1'b1)    n_calc++;
        if (o_inst_complete === 1'b1) n_done++;
        if (o_be_bne === 1'b1)        n_br++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic pulse(input int sel);
        return (sel == 0) ? o_calc_start : o_inst_complete;
    endfunction

    task automatic wait_pulse(input int sel, input int lim, input string tag);
        int i = 0;
        while (pulse(sel) !== 1'b1 && i < lim) begin
            step();
            i++;
        end
        chk(tag, {31'b0, pulse(sel)}, 32'd1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        i_addr = a;
        i_read = 1'b1;
        step();
        i_read = 1'b0;
        chk("rvalid", {31'b0, o_readdatavalid}, 32'd1);
        d = o_readdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        i_addr      = a;
        i_writedata = d;
        i_write     = 1'b1;
        step();
        i_write = 1'b0;
    endtask

    // Present one instruction and wait for its ALU start pulse.
    task automatic issue(input logic [31:0] inst, input string tag);
        i_inst       = inst;
        i_inst_valid = 1'b1;
        i_empty      = 1'b0;
        wait_pulse(0, 10, tag);
        i_inst_valid = 1'b0;
        i_empty      = 1'b1;
    endtask

    logic [31:0] d;
    int          c0, r0, b0;

    initial begin
        rst = 1'b1;
        i_empty = 1'b1;
        i_fetch_complete = 1'b0;
        i_inst = '0;
        i_inst_valid = 1'b0;
        i_calc_complete = 1'b0;
        i_read_mem_complete = 1'b0;
        i_write_mem_complete = 1'b0;
        i_src0 = '0;
        i_src1 = '0;
        i_addr = '0;
        i_read = 1'b0;
        i_write = 1'b0;
        i_writedata = '0;
        step(); step(); step();
        chk("rst_outs", {o_inst_complete, o_calc_start, o_be_bne,
                         o_readdatavalid}, 32'd0);
        chk("rst_rdata", o_readdata, 32'd0);
        rst = 1'b0;

        // Idle with an empty FIFO.
        c0 = n_calc; r0 = n_done;
        repeat (20) step();
        chk("idle_calc", n_calc - c0, 0);
        chk("idle_done", n_done - r0, 0);
        rd(32'h0, d);
        chk("status_idle", d, 32'h10);
        step();
        chk("rvalid_drop", {31'b0, o_readdatavalid}, 32'd0);
        chk("rdata_hold", o_readdata, 32'h10);
        rd(32'hC, d);
        chk("ctrl_rst", d, 32'h1);

        // ALU instruction, completion 3 cycles after start.
        c0 = n_calc; r0 = n_done;
        issue(32'h00221820, "alu_start");
        step();
        chk("alu_start_1cy", {31'b0, o_calc_start}, 32'd0);
        step(); step();
        chk("alu_no_early", n_done - r0, 0);
        i_calc_complete = 1'b1;
        step();
        i_calc_complete = 1'b0;
        chk("alu_retire", {31'b0, o_inst_complete}, 32'd1);
        step();
        chk("alu_retire_1cy", {31'b0, o_inst_complete}, 32'd0);
        chk("alu_calc_cnt", n_calc - c0, 1);
        rd(32'h4, d);
        chk("count_1", d, 32'd1);

        // LW: wrong-kind strobe in MEM_RD is ignored.
        r0 = n_done;
        issue(32'h8C220004, "lw_start");
        step();
        i_calc_complete = 1'b1;
        step();
        i_calc_complete = 1'b0;
        i_write_mem_complete = 1'b1;
        step(); step();
        i_write_mem_complete = 1'b0;
        chk("lw_wr_ignored", n_done - r0, 0);
        i_read_mem_complete = 1'b1;
        step();
        i_read_mem_complete = 1'b0;
        chk("lw_retire", {31'b0, o_inst_complete}, 32'd1);
        step();

        // BEQ taken, BNE not taken with equal operands.
        i_src0 = 32'h5;
        i_src1 = 32'h5;
        b0 = n_br;
        issue(32'h10220003, "beq_start");
        step();
        i_calc_complete = 1'b1;
        step();
        i_calc_complete = 1'b0;
        chk("beq_taken", {31'b0, o_be_bne}, 32'd1);
        step();
        chk("beq_1cy", {31'b0, o_be_bne}, 32'd0);
        chk("beq_retire", {31'b0, o_inst_complete}, 32'd1);
        step();
        issue(32'h14220003, "bne_start");
        step();
        i_calc_complete = 1'b1;
        step();
        i_calc_complete = 1'b0;
        chk("bne_not_taken", {31'b0, o_be_bne}, 32'd0);
        step();
        chk("bne_retire", {31'b0, o_inst_complete}, 32'd1);
        chk("br_pulses", n_br - b0, 1);
        step();
        rd(32'h4, d);
        chk("count_4", d, 32'd4);

        // Disable during EXEC: finish, then park with work pending.
        issue(32'h00221820, "dis_start");
        i_empty = 1'b0;
        step();
        wr(32'hC, 32'h0);
        i_calc_complete = 1'b1;
        step();
        i_calc_complete = 1'b0;
        chk("dis_retire", {31'b0, o_inst_complete}, 32'd1);
        c0 = n_calc;
        repeat (10) step();
        chk("parked_calc", n_calc - c0, 0);
        rd(32'h0, d);
        chk("status_parked", d, 32'h0);
        i_inst = 32'h00431020;
        i_inst_valid = 1'b1;
        wr(32'hC, 32'h1);
        wait_pulse(0, 10, "resume_start");
        i_inst_valid = 1'b0;
        i_empty = 1'b1;
        step();
        i_calc_complete = 1'b1;
        step();
        i_calc_complete = 1'b0;
        chk("resume_retire", {31'b0, o_inst_complete}, 32'd1);

        // Clear count on the same edge as the retire increment.
        wr(32'hC, 32'h3);
        rd(32'h4, d);
        chk("count_clear", d, 32'd0);
        rd(32'h8, d);
        chk("cur_inst", d, 32'h00431020);
        rd(32'h18, d);
        chk("alias_inst", d, 32'h00431020);
        rd(32'hC, d);
        chk("ctrl_selfclr", d, 32'h1);
        wr(32'h4, 32'h55);
        rd(32'h4, d);
        chk("ro_write", d, 32'd0);
        i_read = 1'b1;
        i_addr = 32'hC;
        i_writedata = 32'h0;
        i_write = 1'b1;
        step();
        i_read = 1'b0;
        i_write = 1'b0;
        chk("rw_prewrite", o_readdata, 32'h1);
        rd(32'hC, d);
        chk("rw_written", d, 32'h0);
        wr(32'hC, 32'h1);

        // NOP retires without starting the ALU.
        c0 = n_calc;
        i_inst = 32'hFC000000;
        i_inst_valid = 1'b1;
        i_empty = 1'b0;
        wait_pulse(1, 10, "nop_retire");
        i_inst_valid = 1'b0;
        i_empty = 1'b1;
        chk("nop_no_calc", n_calc - c0, 0);
        step();
        rd(32'h4, d);
        chk("count_nop", d, 32'd1);

        // Reset during MEM_WR aborts without retiring.
        issue(32'hAC220004, "sw_start");
        step();
        i_calc_complete = 1'b1;
        step();
        i_calc_complete = 1'b0;
        r0 = n_done;
        rst = 1'b1;
        i_write_mem_complete = 1'b1;
        step();
        chk("abort_no_retire", {31'b0, o_inst_complete}, 32'd0);
        rst = 1'b0;
        i_write_mem_complete = 1'b0;
        repeat (5) step();
        chk("abort_pulses", n_done - r0, 0);
        rd(32'h4, d);
        chk("abort_count", d, 32'd0);
        rd(32'h8, d);
        chk("abort_inst", d, 32'd0);
        rd(32'h0, d);
        chk("abort_status", d, 32'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
